// File: rtl/bp_mem_cmd_arbiter.sv
// bp_mem_cmd_arbiter: shares one BlackParrot memory port among num_req_p CCEs with per-channel round-robin and in-order response routing.
// Define BP_MEM_ARB_STATS_EN to get per-requester saturating grant counters on stats_o.
module bp_mem_cmd_arbiter_chan #(
  parameter int num_req_p = 2,
  parameter int width_p = 8,
  parameter int tag_els_p = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              elig_i,
  input  logic [num_req_p-1:0][width_p-1:0] data_i,
  output logic [num_req_p-1:0]              yumi_o,
  output logic [width_p-1:0]                mem_o,
  output logic                              mem_v_o,
  input  logic                              mem_yumi_i,
  input  logic                              resp_v_i,
  input  logic [num_req_p-1:0]              resp_ready_i,
  output logic [num_req_p-1:0]              resp_v_o,
  output logic                              resp_ready_o
);
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_width_lp = $clog2(tag_els_p);
  localparam logic [num_req_p-1:0] one_lp = 1;
  logic [id_width_lp-1:0] rr_q, lock_id_q, win, idx, head;
  logic [id_width_lp:0] sum;
  logic locked_q, any, fire, full, empty, pop;
  logic [id_width_lp-1:0] tags_q [tag_els_p];
  logic [ptr_width_lp:0] wr_q, rd_q;
  always_comb begin
    win = locked_q ? lock_id_q : rr_q;
    any = locked_q;
    sum = '0;
    idx = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      sum = {1'b0, rr_q} + (id_width_lp+1)'(i);
      idx = id_width_lp'(sum >= (id_width_lp+1)'(num_req_p) ? sum - (id_width_lp+1)'(num_req_p) : sum);
      if (!locked_q && elig_i[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  // wrap bit set with equal low bits means the tag FIFO holds tag_els_p entries
  assign full = (wr_q ^ rd_q) == {1'b1, {ptr_width_lp{1'b0}}};
  assign empty = wr_q == rd_q;
  assign mem_v_o = reset_n_i & any & ~full;
  assign fire = mem_v_o & mem_yumi_i;
  assign yumi_o = fire ? one_lp << win : '0;
  assign mem_o = data_i[win];
  assign head = tags_q[rd_q[ptr_width_lp-1:0]];
  assign resp_ready_o = reset_n_i & ~empty & resp_ready_i[head];
  assign resp_v_o = (reset_n_i & resp_v_i & ~empty) ? one_lp << head : '0;
  assign pop = resp_v_i & resp_ready_o;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_q <= '0;
      lock_id_q <= '0;
      locked_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      locked_q <= mem_v_o & ~mem_yumi_i;
      lock_id_q <= win;
      if (fire) rr_q <= (win == id_width_lp'(num_req_p - 1)) ? '0 : win + 1'b1;
      if (fire) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i)
    if (fire) tags_q[wr_q[ptr_width_lp-1:0]] <= win;
  a_resp_while_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(resp_v_i && empty));
endmodule

module bp_mem_cmd_arbiter #(
  parameter int num_req_p = 2,
  parameter int cmd_width_p = 8,
  parameter int data_cmd_width_p = 8,
  parameter int resp_width_p = 8,
  parameter int data_resp_width_p = 8,
  parameter int tag_els_p = 8
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,
  input  logic [num_req_p-1:0][cmd_width_p-1:0]       req_cmd_i,
  input  logic [num_req_p-1:0]                        req_cmd_v_i,
  output logic [num_req_p-1:0]                        req_cmd_yumi_o,
  input  logic [num_req_p-1:0][data_cmd_width_p-1:0]  req_data_cmd_i,
  input  logic [num_req_p-1:0]                        req_data_cmd_v_i,
  output logic [num_req_p-1:0]                        req_data_cmd_yumi_o,
  output logic [num_req_p-1:0][resp_width_p-1:0]      req_resp_o,
  output logic [num_req_p-1:0]                        req_resp_v_o,
  input  logic [num_req_p-1:0]                        req_resp_ready_i,
  output logic [num_req_p-1:0][data_resp_width_p-1:0] req_data_resp_o,
  output logic [num_req_p-1:0]                        req_data_resp_v_o,
  input  logic [num_req_p-1:0]                        req_data_resp_ready_i,
  output logic [cmd_width_p-1:0]                      mem_cmd_o,
  output logic                                        mem_cmd_v_o,
  input  logic                                        mem_cmd_yumi_i,
  output logic [data_cmd_width_p-1:0]                 mem_data_cmd_o,
  output logic                                        mem_data_cmd_v_o,
  input  logic                                        mem_data_cmd_yumi_i,
  input  logic [resp_width_p-1:0]                     mem_resp_i,
  input  logic                                        mem_resp_v_i,
  output logic                                        mem_resp_ready_o,
  input  logic [data_resp_width_p-1:0]                mem_data_resp_i,
  input  logic                                        mem_data_resp_v_i,
  output logic                                        mem_data_resp_ready_o,
  output logic [num_req_p-1:0][31:0]                  stats_o
);
  // a pending writeback blocks the same CCE's read so the read cannot overtake it
  logic [num_req_p-1:0] cmd_elig;
  assign cmd_elig = req_cmd_v_i & ~req_data_cmd_v_i;
  bp_mem_cmd_arbiter_chan #(.num_req_p(num_req_p), .width_p(cmd_width_p), .tag_els_p(tag_els_p)) cmd (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .elig_i(cmd_elig),
    .data_i(req_cmd_i),
    .yumi_o(req_cmd_yumi_o),
    .mem_o(mem_cmd_o),
    .mem_v_o(mem_cmd_v_o),
    .mem_yumi_i(mem_cmd_yumi_i),
    .resp_v_i(mem_data_resp_v_i),
    .resp_ready_i(req_data_resp_ready_i),
    .resp_v_o(req_data_resp_v_o),
    .resp_ready_o(mem_data_resp_ready_o)
  );
  bp_mem_cmd_arbiter_chan #(.num_req_p(num_req_p), .width_p(data_cmd_width_p), .tag_els_p(tag_els_p)) data_cmd (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .elig_i(req_data_cmd_v_i),
    .data_i(req_data_cmd_i),
    .yumi_o(req_data_cmd_yumi_o),
    .mem_o(mem_data_cmd_o),
    .mem_v_o(mem_data_cmd_v_o),
    .mem_yumi_i(mem_data_cmd_yumi_i),
    .resp_v_i(mem_resp_v_i),
    .resp_ready_i(req_resp_ready_i),
    .resp_v_o(req_resp_v_o),
    .resp_ready_o(mem_resp_ready_o)
  );
  assign req_resp_o = {num_req_p{mem_resp_i}};
  assign req_data_resp_o = {num_req_p{mem_data_resp_i}};
`ifdef BP_MEM_ARB_STATS_EN
  logic [num_req_p-1:0][31:0] cnt_q;
  logic [num_req_p-1:0][32:0] cnt_sum;
  always_comb
    for (int r = 0; r < num_req_p; r++)
      cnt_sum[r] = {1'b0, cnt_q[r]} + 33'(req_cmd_yumi_o[r]) + 33'(req_data_cmd_yumi_o[r]);
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) cnt_q <= '0;
    else for (int r = 0; r < num_req_p; r++) cnt_q[r] <= cnt_sum[r][32] ? '1 : cnt_sum[r][31:0];
  assign stats_o = cnt_q;
`else
  assign stats_o = '0;
`endif
endmodule
